// File: rtl/xnor_popcount_acc.sv
// rtl/xnor_popcount_acc.sv - XNOR/popcount frame accumulator with saturation and optional thresholding
// Optional feature: define XNOR_PC_THRESH_EN to drive obit from (frame sum >= iTHRESH).
module xnor_popcount_acc #(
  parameter int WL    = 112,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                    iCLK,
  input  logic                    iRSTn,
  input  logic                    iEN,
  input  logic                    iFIRST,
  input  logic                    iLAST,
  input  logic                    iMODE,
  input  logic [$clog2(WL)-1:0]   iADDR,
  input  logic [WL-1:0]           idata,
  input  logic [WL-1:0]           iweight,
  input  logic [ACC_W-1:0]        iTHRESH,
  output logic [ACC_W-1:0]        odata,
  output logic                    oEN,
  output logic                    oSAT,
  output logic                    obit,
  output logic                    oBUSY,
  output logic [CNT_W-1:0]        oCNT
);

  localparam int PW = $clog2(WL + 1);
  // One spare bit above the wider operand so an overflow is always visible.
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t            state, state_next;
  logic [WL-1:0]     x;
  logic [PW-1:0]     p;
  logic [PW-1:0]     s1_p;
  logic              s1_first, s1_last, s1_en;
  logic [ACC_W-1:0]  acc, acc_next;
  logic              sat, sat_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [SW-1:0]     sum;
  logic              clip;
  logic              bit_next;

  assign x = ~(idata ^ iweight);

  always_comb begin
    p = '0;
    if (iMODE) begin
      p = PW'(x[iADDR]);
    end else begin
      for (int i = 0; i < WL; i++) begin
        p = p + PW'(x[i]);
      end
    end
  end

  always_comb begin
    sum      = (s1_first ? SW'(0) : SW'(acc)) + SW'(s1_p);
    clip     = |sum[SW-1:ACC_W];
    acc_next = clip ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    sat_next = (s1_first ? 1'b0 : sat) | clip;
    cnt_next = s1_first ? CNT_W'(1) : cnt + CNT_W'(1);
    state_next = state;
    if (s1_last) begin
      state_next = IDLE;
    end else if (s1_first) begin
      state_next = ACCUM;
    end
  end

`ifdef XNOR_PC_THRESH_EN
  assign bit_next = (acc_next >= iTHRESH);
`else
  logic unused_thresh;
  assign unused_thresh = ^iTHRESH;
  assign bit_next      = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      s1_p     <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_en    <= 1'b0;
      acc      <= '0;
      sat      <= 1'b0;
      cnt      <= '0;
      state    <= IDLE;
      odata    <= '0;
      oEN      <= 1'b0;
      oSAT     <= 1'b0;
      obit     <= 1'b0;
      oBUSY    <= 1'b0;
      oCNT     <= '0;
    end else begin
      s1_p     <= p;
      s1_first <= iFIRST;
      s1_last  <= iLAST;
      s1_en    <= iEN;
      oEN      <= 1'b0;
      if (s1_en) begin
        acc   <= acc_next;
        sat   <= sat_next;
        cnt   <= cnt_next;
        state <= state_next;
        oBUSY <= (state_next == ACCUM);
        if (s1_last) begin
          odata <= acc_next;
          oSAT  <= sat_next;
          oCNT  <= cnt_next;
          obit  <= bit_next;
          oEN   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// tb/tb_xnor_popcount_acc.sv - directed bench for xnor_popcount_acc (ACC_W=16 and ACC_W=8 instances)
module tb_xnor_popcount_acc;

  localparam int WL = 112;
  localparam int AW = $clog2(WL);
`ifdef XNOR_PC_THRESH_EN
  localparam int THR = 1;
`else
  localparam int THR = 0;
`endif

  logic           iCLK = 1'b0;
  logic           iRSTn = 1'b0;
  logic           iEN = 1'b0, iFIRST = 1'b0, iLAST = 1'b0, iMODE = 1'b0;
  logic [AW-1:0]  iADDR = '0;
  logic [WL-1:0]  idata = '0, iweight = '0;
  logic [15:0]    iTHRESH = 16'd100;

  logic [15:0] odata16;
  logic        oen16, osat16, obit16, obusy16;
  logic [7:0]  ocnt16;
  logic [7:0]  odata8;
  logic        oen8, osat8, obit8, obusy8;
  logic [7:0]  ocnt8;

  xnor_popcount_acc #(.WL(WL), .ACC_W(16), .CNT_W(8)) dut16 (
    .iCLK(iCLK), .iRSTn(iRSTn), .iEN(iEN), .iFIRST(iFIRST), .iLAST(iLAST),
    .iMODE(iMODE), .iADDR(iADDR), .idata(idata), .iweight(iweight),
    .iTHRESH(iTHRESH), .odata(odata16), .oEN(oen16), .oSAT(osat16),
    .obit(obit16), .oBUSY(obusy16), .oCNT(ocnt16));

  xnor_popcount_acc #(.WL(WL), .ACC_W(8), .CNT_W(8)) dut8 (
    .iCLK(iCLK), .iRSTn(iRSTn), .iEN(iEN), .iFIRST(iFIRST), .iLAST(iLAST),
    .iMODE(iMODE), .iADDR(iADDR), .idata(idata), .iweight(iweight),
    .iTHRESH(iTHRESH[7:0]), .odata(odata8), .oEN(oen8), .oSAT(osat8),
    .obit(obit8), .oBUSY(obusy8), .oCNT(ocnt8));

  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: state advances when a chunk is presented; visible outputs lag by two edges.
  typedef struct {
    int acc; int sat; int cnt; int busy;
    int en; int data; int osat; int ocnt; int obit;
  } ms_t;

  function automatic ms_t step(input ms_t s, input int maxv, input int thr);
    ms_t n;
    int  p;
    n    = s;
    n.en = 0;
    if (!iEN) return n;
    if (iMODE) p = (idata[iADDR] == iweight[iADDR]) ? 1 : 0;
    else       p = $countones(~(idata ^ iweight));
    if (iFIRST) begin n.acc = 0; n.sat = 0; n.cnt = 0; end
    n.acc = n.acc + p;
    if (n.acc > maxv) begin n.acc = maxv; n.sat = 1; end
    n.cnt = (n.cnt + 1) % 256;
    if (iLAST) begin
      n.busy = 0; n.en = 1; n.data = n.acc; n.osat = n.sat; n.ocnt = n.cnt;
      n.obit = (THR != 0 && n.acc >= thr) ? 1 : 0;
    end else if (iFIRST) begin
      n.busy = 1;
    end
    return n;
  endfunction

  ms_t m16, a16, b16, m8, a8, b8;
  ms_t zero_ms = '{default: 0};

  always @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      m16 <= zero_ms; a16 <= zero_ms; b16 <= zero_ms;
      m8  <= zero_ms; a8  <= zero_ms; b8  <= zero_ms;
    end else begin
      m16 <= step(m16, 65535, int'(iTHRESH));
      a16 <= step(m16, 65535, int'(iTHRESH));
      b16 <= a16;
      m8  <= step(m8, 255, int'(iTHRESH[7:0]));
      a8  <= step(m8, 255, int'(iTHRESH[7:0]));
      b8  <= a8;
    end
  end

  bit  chk_on = 1'b0;
  ms_t r16[$], r8[$];

  always @(negedge iCLK) begin
    if (chk_on) begin
      chk("oEN16",   int'(oen16),   b16.en);
      chk("odata16", int'(odata16), b16.data);
      chk("oSAT16",  int'(osat16),  b16.osat);
      chk("oCNT16",  int'(ocnt16),  b16.ocnt);
      chk("obit16",  int'(obit16),  b16.obit);
      chk("oBUSY16", int'(obusy16), b16.busy);
      chk("oEN8",    int'(oen8),    b8.en);
      chk("odata8",  int'(odata8),  b8.data);
      chk("oSAT8",   int'(osat8),   b8.osat);
      chk("oCNT8",   int'(ocnt8),   b8.ocnt);
      chk("obit8",   int'(obit8),   b8.obit);
      chk("oBUSY8",  int'(obusy8),  b8.busy);
      if (oen16) r16.push_back('{0, 0, 0, 0, 1, int'(odata16), int'(osat16), int'(ocnt16), int'(obit16)});
      if (oen8)  r8.push_back('{0, 0, 0, 0, 1, int'(odata8), int'(osat8), int'(ocnt8), int'(obit8)});
    end
  end

  function automatic logic [WL-1:0] ones(input int n);
    logic [WL-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic send(input bit f, input bit l, input bit m, input int a,
                      input logic [WL-1:0] d, input logic [WL-1:0] w);
    iEN = 1'b1; iFIRST = f; iLAST = l; iMODE = m; iADDR = AW'(a);
    idata = d; iweight = w;
    @(posedge iCLK); #1;
    iEN = 1'b0; iFIRST = 1'b0; iLAST = 1'b0;
  endtask

  // n matching bits: idata all zero, iweight zero only in the low n bits
  task automatic send_n(input bit f, input bit l, input int n);
    send(f, l, 1'b0, 0, '0, ~ones(n));
  endtask

  task automatic bubble(input int n);
    repeat (n) begin @(posedge iCLK); #1; end
  endtask

  int e_data16[9] = '{112, 168, 4, 336, 10, 7, 99, 100, 105};
  int e_data8[9]  = '{112, 168, 4, 255, 10, 7, 99, 100, 105};
  int e_cnt[9]    = '{1, 3, 4, 3, 1, 1, 1, 1, 2};
  int e_sat8[9]   = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
  int e_bit[9]    = '{1, 1, 0, 1, 0, 0, 0, 1, 1};

  initial begin
    logic [WL-1:0] pat;
    logic [WL-1:0] mode_w;
    pat    = {4{28'h9A5C36E}};
    mode_w = ~ones(6) | ones(5);
    @(posedge iCLK); #1;
    chk_on = 1'b1;
    @(negedge iCLK);
    chk("reset_odata", int'(odata16), 0);
    chk("reset_oEN",   int'(oen16),   0);
    chk("reset_oBUSY", int'(obusy16), 0);
    @(posedge iCLK); #1;
    iRSTn = 1'b1;
    bubble(1);

    send(1, 1, 0, 0, ones(WL), ones(WL));
    bubble(3);

    send(1, 0, 0, 0, pat, ~pat);
    bubble(1);
    send(0, 0, 0, 0, pat, pat);
    send_n(0, 1, 56);
    bubble(3);

    send(1, 0, 1, 5, '0, mode_w);
    send(0, 0, 1, 5, '0, mode_w);
    send(0, 0, 1, 5, '0, mode_w);
    send(0, 1, 1, 5, '0, mode_w);
    bubble(3);

    send(1, 0, 0, 0, ones(WL), ones(WL));
    send(0, 0, 0, 0, ones(WL), ones(WL));
    send(0, 1, 0, 0, ones(WL), ones(WL));
    send_n(1, 1, 10);
    bubble(3);

    send_n(1, 0, 20);
    send_n(0, 0, 30);
    iRSTn = 1'b0;
    @(negedge iCLK);
    chk("midreset_oBUSY", int'(obusy16), 0);
    chk("midreset_odata", int'(odata16), 0);
    @(posedge iCLK); #1;
    iRSTn = 1'b1;
    bubble(1);
    send_n(1, 1, 7);
    bubble(3);

    send_n(1, 1, 99);
    send_n(1, 1, 100);
    bubble(1);
    send_n(0, 1, 5);
    bubble(4);

    chk("results16", r16.size(), 9);
    chk("results8",  r8.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < r16.size()) begin
        chk($sformatf("lit16_data[%0d]", i), r16[i].data, e_data16[i]);
        chk($sformatf("lit16_cnt[%0d]", i),  r16[i].ocnt, e_cnt[i]);
        chk($sformatf("lit16_sat[%0d]", i),  r16[i].osat, 0);
        chk($sformatf("lit16_bit[%0d]", i),  r16[i].obit, e_bit[i] * THR);
      end
      if (i < r8.size()) begin
        chk($sformatf("lit8_data[%0d]", i), r8[i].data, e_data8[i]);
        chk($sformatf("lit8_sat[%0d]", i),  r8[i].osat, e_sat8[i]);
        chk($sformatf("lit8_bit[%0d]", i),  r8[i].obit, e_bit[i] * THR);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
